fb_swap_scheduler: RTL and testbench

- Double-buffer swap controller that sits in front of the AXI-stream framebuffer writer.
- On each swap request it commits the current back buffer to memory via the writer's commit_fb/fb_committed handshake.
- It optionally waits for display vsync, then flips front/back and publishes the new scanout address to the display reader.
- It serialises swap requests, holds one pending request, and flags any request dropped on overflow.

---
 rtl/fb_swap_scheduler.sv | 160 ++++++++++++++++
 tb/tb_fb_swap_scheduler.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_swap_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : fb_swap_scheduler
// Description : Double-buffer swap controller. Commits the back buffer through
//               the writer handshake, optionally waits for vsync, then flips.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module fb_swap_scheduler #(
  parameter int ADDR_WIDTH          = 32,
  parameter int FB_SIZE_IN_PIXEL_LG = 20,
  parameter int SWAP_CNT_WIDTH      = 16
) (
  input  logic                           aclk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          cfg_fb0_addr,
  input  logic [ADDR_WIDTH-1:0]          cfg_fb1_addr,
  input  logic [FB_SIZE_IN_PIXEL_LG-1:0] cfg_fb_size,
  input  logic                           cfg_wait_vsync,
  input  logic                           swap_req,
  input  logic                           vsync,
  output logic                           commit_fb,
  output logic [ADDR_WIDTH-1:0]          fb_addr,
  output logic [FB_SIZE_IN_PIXEL_LG-1:0] fb_size,
  input  logic                           fb_committed,
  output logic [ADDR_WIDTH-1:0]          disp_fb_addr,
  output logic                           disp_fb_update,
  output logic                           back_idx,
  output logic                           swap_busy,
  output logic                           swap_dropped,
  output logic [SWAP_CNT_WIDTH-1:0]      swap_count
);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_REQ   = 3'd1;
  localparam logic [2:0] c_ST_WRITE = 3'd2;
  localparam logic [2:0] c_ST_VSYNC = 3'd3;
  localparam logic [2:0] c_ST_FLIP  = 3'd4;

  logic [2:0]                     r_state;
  logic [2:0]                     w_next_state;
  logic                           r_commit_fb;
  logic [ADDR_WIDTH-1:0]          r_fb_addr;
  logic [FB_SIZE_IN_PIXEL_LG-1:0] r_fb_size;
  logic                           r_wait_vsync;
  logic                           r_back_idx;
  logic                           r_disp_fb_update;
  logic                           r_swap_dropped;
  logic                           r_pending;
  logic [SWAP_CNT_WIDTH-1:0]      r_swap_count;

  logic w_start;
  logic w_commit_set;
  logic w_commit_clr;
  logic w_enter_flip;
  logic w_swap_busy;

  // State register
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (swap_req || r_pending) begin
          if (cfg_fb_size == '0) begin
            w_next_state = cfg_wait_vsync ? c_ST_VSYNC : c_ST_FLIP;
          end else begin
            w_next_state = c_ST_REQ;
          end
        end
      end
      c_ST_REQ: begin
        if (!fb_committed) w_next_state = c_ST_WRITE;
      end
      c_ST_WRITE: begin
        if (fb_committed) w_next_state = r_wait_vsync ? c_ST_VSYNC : c_ST_FLIP;
      end
      c_ST_VSYNC: begin
        if (vsync) w_next_state = c_ST_FLIP;
      end
      c_ST_FLIP: begin
        w_next_state = c_ST_IDLE;
      end
      default: begin
        w_next_state = c_ST_IDLE;
      end
    endcase
  end

  // Output / strobe decode
  always_comb begin
    w_start      = (r_state == c_ST_IDLE) && (swap_req || r_pending);
    w_commit_set = w_start && (cfg_fb_size != '0);
    w_commit_clr = (r_state == c_ST_REQ) && !fb_committed;
    // Flip side effects land on the edge entering FLIP, so the update pulse
    // coincides with the FLIP cycle while swap_busy is still high.
    w_enter_flip = (w_next_state == c_ST_FLIP) && (r_state != c_ST_FLIP);
    w_swap_busy  = (r_state != c_ST_IDLE);
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_commit_fb      <= 1'b0;
      r_fb_addr        <= '0;
      r_fb_size        <= '0;
      r_wait_vsync     <= 1'b0;
      r_back_idx       <= 1'b0;
      r_disp_fb_update <= 1'b0;
      r_swap_dropped   <= 1'b0;
      r_pending        <= 1'b0;
      r_swap_count     <= '0;
    end else begin
      r_disp_fb_update <= w_enter_flip;

      if (w_start) begin
        r_fb_size    <= cfg_fb_size;
        r_wait_vsync <= cfg_wait_vsync;
        r_fb_addr    <= r_back_idx ? cfg_fb1_addr : cfg_fb0_addr;
      end

      if (w_commit_set) begin
        r_commit_fb <= 1'b1;
      end else if (w_commit_clr) begin
        r_commit_fb <= 1'b0;
      end

      if (w_enter_flip) begin
        r_back_idx   <= ~r_back_idx;
        r_swap_count <= r_swap_count + 1'b1;
      end

      // A request arriving while a pending one is being launched refills the slot.
      if (r_state == c_ST_IDLE) begin
        if (r_pending) r_pending <= swap_req;
      end else if (swap_req) begin
        r_pending <= 1'b1;
        if (r_pending) r_swap_dropped <= 1'b1;
      end
    end
  end

  assign commit_fb      = r_commit_fb;
  assign fb_addr        = r_fb_addr;
  assign fb_size        = r_fb_size;
  assign disp_fb_addr   = r_back_idx ? cfg_fb0_addr : cfg_fb1_addr;
  assign disp_fb_update = r_disp_fb_update;
  assign back_idx       = r_back_idx;
  assign swap_busy      = w_swap_busy;
  assign swap_dropped   = r_swap_dropped;
  assign swap_count     = r_swap_count;

endmodule
`default_nettype wire

// File: tb/tb_fb_swap_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_fb_swap_scheduler
// Description : Self-checking bench for fb_swap_scheduler with writer model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_fb_swap_scheduler;

  localparam int AW = 32;
  localparam int SW = 20;
  localparam int CW = 8;

  logic          aclk = 1'b0;
  logic          reset;
  logic [AW-1:0] cfg_fb0_addr, cfg_fb1_addr;
  logic [SW-1:0] cfg_fb_size;
  logic          cfg_wait_vsync, swap_req, vsync;
  logic          fb_committed = 1'b1;
  logic          commit_fb;
  logic [AW-1:0] fb_addr, disp_fb_addr;
  logic [SW-1:0] fb_size;
  logic          disp_fb_update, back_idx, swap_busy, swap_dropped;
  logic [CW-1:0] swap_count;

  fb_swap_scheduler #(
    .ADDR_WIDTH          (AW),
    .FB_SIZE_IN_PIXEL_LG (SW),
    .SWAP_CNT_WIDTH      (CW)
  ) dut (
    .aclk           (aclk),
    .reset          (reset),
    .cfg_fb0_addr   (cfg_fb0_addr),
    .cfg_fb1_addr   (cfg_fb1_addr),
    .cfg_fb_size    (cfg_fb_size),
    .cfg_wait_vsync (cfg_wait_vsync),
    .swap_req       (swap_req),
    .vsync          (vsync),
    .commit_fb      (commit_fb),
    .fb_addr        (fb_addr),
    .fb_size        (fb_size),
    .fb_committed   (fb_committed),
    .disp_fb_addr   (disp_fb_addr),
    .disp_fb_update (disp_fb_update),
    .back_idx       (back_idx),
    .swap_busy      (swap_busy),
    .swap_dropped   (swap_dropped),
    .swap_count     (swap_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [SW-1:0] size;
  } commit_t;

  typedef struct {
    logic [AW-1:0] fb0;
    logic [AW-1:0] fb1;
    logic [SW-1:0] size;
    logic [AW-1:0] exp_addr;
    logic          exp_back;
    logic [CW-1:0] exp_count;
    int            budget;
  } vec_t;

  commit_t       commit_q[$];
  logic [AW-1:0] flip_q[$];
  vec_t          vecs[5];

  int n_checks   = 0;
  int n_errors   = 0;
  int n_updates  = 0;
  int drop_delay = 2;
  int busy_len   = 100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_commit(input logic [AW-1:0] addr, input logic [SW-1:0] size);
    commit_t ce;
    ce.addr = addr;
    ce.size = size;
    commit_q.push_back(ce);
  endtask

  // Writer model: drops fb_committed drop_delay cycles after a commit, raises it busy_len later.
  int wr_state = 0;
  int wr_cnt   = 0;
  always @(negedge aclk) begin
    if (reset) begin
      wr_state     = 0;
      wr_cnt       = 0;
      fb_committed = 1'b1;
    end else begin
      case (wr_state)
        0: if (commit_fb) begin wr_cnt = 1; wr_state = 1; end
        1: begin
          if (wr_cnt >= drop_delay) begin
            fb_committed = 1'b0;
            wr_cnt       = 0;
            wr_state     = 2;
          end else begin
            wr_cnt++;
          end
        end
        2: begin
          wr_cnt++;
          if (wr_cnt >= busy_len) begin
            fb_committed = 1'b1;
            wr_state     = 0;
          end
        end
        default: wr_state = 0;
      endcase
    end
  end

  // Scoreboard monitor
  logic    mon_prev_commit = 1'b0;
  logic    mon_prev_upd    = 1'b0;
  int      mon_commit_len  = 0;
  commit_t mon_e;
  always @(negedge aclk) begin
    if (reset) begin
      mon_prev_commit = 1'b0;
      mon_prev_upd    = 1'b0;
      mon_commit_len  = 0;
    end else begin
      if (commit_fb && !mon_prev_commit) begin
        check("commit_expected", commit_q.size() != 0, 1);
        if (commit_q.size() != 0) begin
          mon_e = commit_q.pop_front();
          check("commit_fb_addr", fb_addr, mon_e.addr);
          check("commit_fb_size", fb_size, mon_e.size);
        end
      end
      if (commit_fb) begin
        mon_commit_len++;
      end else if (mon_prev_commit) begin
        check("commit_len", mon_commit_len, drop_delay + 1);
        mon_commit_len = 0;
      end
      mon_prev_commit = commit_fb;

      if (disp_fb_update) begin
        n_updates++;
        check("update_single_cycle", mon_prev_upd, 0);
        check("busy_during_update", swap_busy, 1);
        check("flip_expected", flip_q.size() != 0, 1);
        if (flip_q.size() != 0) check("flip_disp_addr", disp_fb_addr, flip_q.pop_front());
      end
      mon_prev_upd = disp_fb_update;
    end
  end

  task automatic pulse_swap();
    @(negedge aclk);
    swap_req = 1'b1;
    @(negedge aclk);
    swap_req = 1'b0;
  endtask

  task automatic wait_updates(input int target, input int budget, input string name);
    int c = 0;
    while (n_updates < target && c < budget) begin
      @(negedge aclk);
      c++;
    end
    check(name, n_updates, target);
  endtask

  task automatic wait_committed(input logic val, input int budget, input string name);
    int c = 0;
    while (fb_committed !== val && c < budget) begin
      @(negedge aclk);
      c++;
    end
    check(name, fb_committed, val);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int hi;
    int c;
    logic idx;

    reset          = 1'b1;
    swap_req       = 1'b0;
    vsync          = 1'b0;
    cfg_fb0_addr   = 32'h1000_0000;
    cfg_fb1_addr   = 32'h1020_0000;
    cfg_fb_size    = 20'd307200;
    cfg_wait_vsync = 1'b0;

    vecs[0] = '{32'h1000_0000, 32'h1020_0000, 20'd307200,  32'h1000_0000, 1'b1, 8'd1, 200};
    vecs[1] = '{32'h1000_0000, 32'h1020_0000, 20'd1,       32'h1020_0000, 1'b0, 8'd2, 200};
    vecs[2] = '{32'h2000_0000, 32'h2040_0000, 20'hFFFFF,   32'h2000_0000, 1'b1, 8'd3, 200};
    vecs[3] = '{32'h2000_0000, 32'h2040_0000, 20'd0,       32'h2040_0000, 1'b0, 8'd4, 3};
    vecs[4] = '{32'hDEAD_0000, 32'hBEEF_0000, 20'd1234,    32'hDEAD_0000, 1'b1, 8'd5, 200};

    repeat (3) @(negedge aclk);
    check("rst_commit_fb", commit_fb, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_size", fb_size, 0);
    check("rst_back_idx", back_idx, 0);
    check("rst_disp_update", disp_fb_update, 0);
    check("rst_swap_busy", swap_busy, 0);
    check("rst_swap_dropped", swap_dropped, 0);
    check("rst_swap_count", swap_count, 0);
    check("rst_disp_addr", disp_fb_addr, 32'h1020_0000);
    reset = 1'b0;

    // Table-driven single swaps, no vsync wait
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      cfg_fb0_addr   = vecs[i].fb0;
      cfg_fb1_addr   = vecs[i].fb1;
      cfg_fb_size    = vecs[i].size;
      cfg_wait_vsync = 1'b0;
      if (vecs[i].size != 0) expect_commit(vecs[i].exp_addr, vecs[i].size);
      flip_q.push_back(vecs[i].exp_addr);
      base     = n_updates;
      swap_req = 1'b1;
      @(negedge aclk);
      swap_req = 1'b0;
      wait_updates(base + 1, vecs[i].budget, "vec_flip_done");
      repeat (2) @(negedge aclk);
      check("vec_back_idx", back_idx, vecs[i].exp_back);
      check("vec_swap_count", swap_count, vecs[i].exp_count);
      check("vec_disp_addr", disp_fb_addr, vecs[i].exp_addr);
      check("vec_idle_busy", swap_busy, 0);
      check("vec_commit_low", commit_fb, 0);
      check("vec_single_update", n_updates, base + 1);
    end

    // Vsync gating: early vsync ignored, flip follows the later one
    @(negedge aclk);
    cfg_fb0_addr   = 32'h1000_0000;
    cfg_fb1_addr   = 32'h1020_0000;
    cfg_fb_size    = 20'd307200;
    cfg_wait_vsync = 1'b1;
    expect_commit(32'h1020_0000, 20'd307200);
    flip_q.push_back(32'h1020_0000);
    base = n_updates;
    pulse_swap();
    wait_committed(1'b0, 20, "vs_writer_started");
    repeat (2) @(negedge aclk);
    vsync = 1'b1;
    @(negedge aclk);
    vsync = 1'b0;
    wait_committed(1'b1, 200, "vs_writer_done");
    repeat (50) @(negedge aclk);
    check("vs_early_ignored", n_updates, base);
    check("vs_busy_waiting", swap_busy, 1);
    vsync = 1'b1;
    @(negedge aclk);
    vsync = 1'b0;
    check("vs_flip_pulse", disp_fb_update, 1);
    @(negedge aclk);
    check("vs_pulse_end", disp_fb_update, 0);
    repeat (2) @(negedge aclk);
    check("vs_one_update", n_updates, base + 1);
    check("vs_swap_count", swap_count, 6);
    check("vs_back_idx", back_idx, 0);
    cfg_wait_vsync = 1'b0;

    // Reset mid-WRITE aborts with no flip
    expect_commit(32'h1000_0000, 20'd307200);
    pulse_swap();
    wait_committed(1'b0, 20, "rw_writer_started");
    repeat (5) @(negedge aclk);
    base  = n_updates;
    reset = 1'b1;
    repeat (2) @(negedge aclk);
    check("rw_commit_fb", commit_fb, 0);
    check("rw_fb_addr", fb_addr, 0);
    check("rw_fb_size", fb_size, 0);
    check("rw_back_idx", back_idx, 0);
    check("rw_busy", swap_busy, 0);
    check("rw_swap_count", swap_count, 0);
    check("rw_disp_update", disp_fb_update, 0);
    check("rw_disp_addr", disp_fb_addr, 32'h1020_0000);
    commit_q.delete();
    flip_q.delete();
    reset = 1'b0;
    @(negedge aclk);
    check("rw_no_update", n_updates, base);

    // Back-to-back: one pending serviced, later ones dropped
    expect_commit(32'h1000_0000, 20'd307200);
    expect_commit(32'h1020_0000, 20'd307200);
    flip_q.push_back(32'h1000_0000);
    flip_q.push_back(32'h1020_0000);
    base = n_updates;
    pulse_swap();
    repeat (10) @(negedge aclk);
    check("b2b_not_dropped_yet", swap_dropped, 0);
    pulse_swap();
    repeat (5) @(negedge aclk);
    pulse_swap();
    repeat (5) @(negedge aclk);
    pulse_swap();
    wait_updates(base + 2, 600, "b2b_two_flips");
    repeat (3) @(negedge aclk);
    check("b2b_swap_count", swap_count, 2);
    check("b2b_dropped", swap_dropped, 1);
    check("b2b_back_idx", back_idx, 0);
    check("b2b_idle", swap_busy, 0);
    check("b2b_no_extra", n_updates, base + 2);

    // Writer stall: commit_fb held high while fb_committed stays 1
    drop_delay = 500;
    expect_commit(32'h1000_0000, 20'd307200);
    flip_q.push_back(32'h1000_0000);
    base = n_updates;
    pulse_swap();
    c = 0;
    while (!commit_fb && c < 5) begin
      @(negedge aclk);
      c++;
    end
    check("stall_commit_seen", commit_fb, 1);
    hi = 0;
    repeat (500) begin
      @(negedge aclk);
      if (commit_fb) hi++;
    end
    check("stall_commit_high", hi, 500);
    check("stall_no_flip", n_updates, base);
    wait_updates(base + 1, 300, "stall_flip_done");
    repeat (2) @(negedge aclk);
    drop_delay = 2;
    check("stall_swap_count", swap_count, 3);

    // Counter wrap with zero-size swaps
    reset = 1'b1;
    repeat (2) @(negedge aclk);
    commit_q.delete();
    flip_q.delete();
    reset = 1'b0;
    cfg_fb_size = 20'd0;
    @(negedge aclk);
    check("wrap_start_count", swap_count, 0);
    base = n_updates;
    idx  = 1'b0;
    for (int k = 0; k < 255; k++) begin
      @(negedge aclk);
      swap_req = 1'b1;
      flip_q.push_back(idx ? cfg_fb1_addr : cfg_fb0_addr);
      idx = ~idx;
      @(negedge aclk);
      swap_req = 1'b0;
    end
    repeat (3) @(negedge aclk);
    check("wrap_count_max", swap_count, 8'hFF);
    flip_q.push_back(idx ? cfg_fb1_addr : cfg_fb0_addr);
    pulse_swap();
    repeat (3) @(negedge aclk);
    check("wrap_count_zero", swap_count, 0);
    check("wrap_updates", n_updates, base + 256);
    check("wrap_no_commit", commit_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
